// File: rtl/magma_pkg.sv
// Shared Magma constants, types, tc26 Pi boxes and key-schedule helpers.
// The round-key order follows the MAGMA_ENC_DECRYPT_EN build option in the encoder top.
package magma_pkg;

    localparam int unsigned MAGMA_ROUNDS = 32;

    typedef logic [63:0]  block_t;
    typedef logic [31:0]  half_t;
    typedef logic [255:0] key_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    // Row i is applied to nibble i of the 32-bit word (pi0 on bits [3:0]).
    localparam logic [3:0] PI [8][16] = '{
        '{4'd12, 4'd4,  4'd6,  4'd2,  4'd10, 4'd5,  4'd11, 4'd9,
          4'd14, 4'd8,  4'd13, 4'd7,  4'd0,  4'd3,  4'd15, 4'd1},
        '{4'd6,  4'd8,  4'd2,  4'd3,  4'd9,  4'd10, 4'd5,  4'd12,
          4'd1,  4'd14, 4'd4,  4'd7,  4'd11, 4'd13, 4'd0,  4'd15},
        '{4'd11, 4'd3,  4'd5,  4'd8,  4'd2,  4'd15, 4'd10, 4'd13,
          4'd14, 4'd1,  4'd7,  4'd4,  4'd12, 4'd9,  4'd6,  4'd0},
        '{4'd12, 4'd8,  4'd2,  4'd1,  4'd13, 4'd4,  4'd15, 4'd6,
          4'd7,  4'd0,  4'd10, 4'd5,  4'd3,  4'd14, 4'd9,  4'd11},
        '{4'd7,  4'd15, 4'd5,  4'd10, 4'd8,  4'd1,  4'd6,  4'd13,
          4'd0,  4'd9,  4'd3,  4'd14, 4'd11, 4'd4,  4'd2,  4'd12},
        '{4'd5,  4'd13, 4'd15, 4'd6,  4'd9,  4'd2,  4'd12, 4'd10,
          4'd11, 4'd7,  4'd8,  4'd1,  4'd4,  4'd3,  4'd14, 4'd0},
        '{4'd8,  4'd14, 4'd2,  4'd5,  4'd6,  4'd9,  4'd1,  4'd12,
          4'd15, 4'd4,  4'd11, 4'd0,  4'd13, 4'd10, 4'd3,  4'd7},
        '{4'd1,  4'd7,  4'd14, 4'd13, 4'd0,  4'd5,  4'd8,  4'd3,
          4'd4,  4'd15, 4'd10, 4'd6,  4'd9,  4'd12, 4'd11, 4'd2}
    };

    // K1 is the most significant word of the key, K8 the least; idx runs 1..8.
    function automatic half_t key_word(key_t key, logic [3:0] idx);
        return key[32 * (8 - int'(idx)) +: 32];
    endfunction

    function automatic logic [3:0] round_key_idx(logic [4:0] rnd, logic decrypt);
        logic [3:0] low;
        low = {1'b0, rnd[2:0]};
        if ((decrypt && rnd < 5'd8) || (!decrypt && rnd < 5'd24)) begin
            return low + 4'd1;
        end
        return 4'd8 - low;
    endfunction

endpackage

// File: rtl/magma_encoder_iter_if.sv
// Valid/ready stream bundle for the iterative Magma encoder.
// MAGMA_ENC_DECRYPT_EN adds the in_decrypt request bit.
interface magma_encoder_iter_if
    import magma_pkg::*;
;
    logic   in_valid;
    logic   in_ready;
    block_t in_block;
    key_t   in_key;
`ifdef MAGMA_ENC_DECRYPT_EN
    logic   in_decrypt;
`endif
    logic   out_valid;
    logic   out_ready;
    block_t out_block;

`ifdef MAGMA_ENC_DECRYPT_EN
    modport slave (input in_valid, in_block, in_key, in_decrypt, out_ready,
                   output in_ready, out_valid, out_block);
    modport master (output in_valid, in_block, in_key, in_decrypt, out_ready,
                    input in_ready, out_valid, out_block);
`else
    modport slave (input in_valid, in_block, in_key, out_ready,
                   output in_ready, out_valid, out_block);
    modport master (output in_valid, in_block, in_key, out_ready,
                    input in_ready, out_valid, out_block);
`endif
endinterface

// File: rtl/magma_round.sv
// One combinational Magma Feistel round: g(x,k) = ROTL11(S(x + k)) plus the half swap.
// The last round keeps the halves in place.
module magma_round
    import magma_pkg::*;
(
    input  half_t  a1,
    input  half_t  a0,
    input  half_t  k,
    input  logic   last,
    output block_t nxt
);
    half_t sum, sub, f;

    always_comb begin
        sum = a0 + k;
        sub = '0;
        for (int i = 0; i < 8; i++) begin
            sub[4*i +: 4] = PI[i][sum[4*i +: 4]];
        end
        f   = {sub[20:0], sub[31:21]} ^ a1;
        nxt = last ? {f, a0} : {a0, f};
    end
endmodule

// File: rtl/magma_encoder_iter.sv
// Iterative Magma encryptor: one Feistel round per clock, 32 rounds per block.
// Define MAGMA_ENC_DECRYPT_EN to add in_decrypt, which selects the decryption key order.
module magma_encoder_iter
    import magma_pkg::*;
(
    input logic                 clk,
    input logic                 rst_n,
    magma_encoder_iter_if.slave bus
);
    state_e     state_q, state_d;
    logic [4:0] rnd_q, rnd_d;
    key_t       key_q, key_d;
    block_t     blk_q, blk_d;
    block_t     ob_q, ob_d;
    logic       ov_q, ov_d;
    logic       decrypt;
    logic       last;
    half_t      rkey;
    block_t     round_out;

`ifdef MAGMA_ENC_DECRYPT_EN
    logic dec_q, dec_d;
    assign decrypt = dec_q;
`else
    assign decrypt = 1'b0;
`endif

    assign last = (rnd_q == 5'(MAGMA_ROUNDS - 1));
    assign rkey = key_word(key_q, round_key_idx(rnd_q, decrypt));

    magma_round u_round (
        .a1   (blk_q[63:32]),
        .a0   (blk_q[31:0]),
        .k    (rkey),
        .last (last),
        .nxt  (round_out)
    );

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = ov_q;
    assign bus.out_block = ob_q;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        key_d   = key_q;
        blk_d   = blk_q;
        ob_d    = ob_q;
        ov_d    = ov_q;
`ifdef MAGMA_ENC_DECRYPT_EN
        dec_d   = dec_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = RUN;
                    rnd_d   = '0;
                    key_d   = bus.in_key;
                    blk_d   = bus.in_block;
`ifdef MAGMA_ENC_DECRYPT_EN
                    dec_d   = bus.in_decrypt;
`endif
                end
            end
            RUN: begin
                if (last) begin
                    state_d = DONE;
                    ob_d    = round_out;
                    ov_d    = 1'b1;
                end else begin
                    blk_d = round_out;
                    rnd_d = rnd_q + 5'd1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                    ov_d    = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rnd_q   <= '0;
            key_q   <= '0;
            blk_q   <= '0;
            ob_q    <= '0;
            ov_q    <= 1'b0;
`ifdef MAGMA_ENC_DECRYPT_EN
            dec_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            key_q   <= key_d;
            blk_q   <= blk_d;
            ob_q    <= ob_d;
            ov_q    <= ov_d;
`ifdef MAGMA_ENC_DECRYPT_EN
            dec_q   <= dec_d;
`endif
        end
    end
endmodule

// File: tb/tb_magma_encoder_iter.sv
// Self-checking bench for magma_encoder_iter: fixed tc26 vector, stalls, back-to-back,
// mid-run reset and randomized blocks checked against a round-loop reference model.
module tb_magma_encoder_iter;

    localparam logic [255:0] KEY_A = 256'hffeeddccbbaa99887766554433221100f0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
    localparam logic [63:0]  PT_A  = 64'hfedcba9876543210;
    localparam logic [63:0]  CT_A  = 64'h4ee901e5c2d8ca3d;

    // Pi boxes, nibble j of row i is Pi_i(j) reading left to right.
    localparam logic [63:0] SBOX [8] = '{
        64'hc462a5b9e8d703f1, 64'h68239a5c1e47bd0f, 64'hb3582fade174c960, 64'hc821d4f670a53e9b,
        64'h7f5a816d093eb42c, 64'h5df692cab78143e0, 64'h8e25691cf4b0da37, 64'h17ed05834fa69cb2
    };

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;

    magma_encoder_iter_if bus ();

    magma_encoder_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] ref_magma(logic [63:0] pt, logic [255:0] key, bit dec);
        logic [31:0] k [8];
        logic [31:0] enc_rk [32];
        logic [31:0] rk [32];
        logic [31:0] a1, a0, t, s;
        logic [63:0] row;
        for (int i = 0; i < 8; i++) k[i] = key[255 - 32*i -: 32];
        for (int i = 0; i < 32; i++) enc_rk[i] = (i < 24) ? k[i % 8] : k[7 - i % 8];
        for (int i = 0; i < 32; i++) rk[i] = dec ? enc_rk[31 - i] : enc_rk[i];
        a1 = pt[63:32];
        a0 = pt[31:0];
        for (int i = 0; i < 32; i++) begin
            t = a0 + rk[i];
            s = '0;
            for (int j = 0; j < 8; j++) begin
                int nib;
                row = SBOX[j];
                nib = int'(t[4*j +: 4]);
                s[4*j +: 4] = row[63 - 4*nib -: 4];
            end
            s = {s[20:0], s[31:21]} ^ a1;
            if (i == 31) return {s, a0};
            a1 = a0;
            a0 = s;
        end
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a block, wait for the accept edge and count edges until out_valid.
    task automatic accept_and_wait(input logic [63:0] blk, input logic [255:0] key, input bit dec,
                                   output int cyc);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_block = blk;
        bus.in_key   = key;
`ifdef MAGMA_ENC_DECRYPT_EN
        bus.in_decrypt = dec;
`else
        if (dec) $display("note: decrypt request ignored in this build");
`endif
        while (!bus.in_ready && guard < 100) begin
            tick();
            guard++;
        end
        tick();
        bus.in_valid = 1'b0;
        cyc = 0;
        while (!bus.out_valid && cyc < 100) begin
            tick();
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_block = '0;
        bus.in_key = '0;
        bus.out_ready = 1'b1;
`ifdef MAGMA_ENC_DECRYPT_EN
        bus.in_decrypt = 1'b0;
`endif
        repeat (3) tick();
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid);
        end
        n_vec++;
        if (bus.out_block !== 64'h0) begin
            n_fail++; $display("FAIL reset_out_block got %h want 0", bus.out_block);
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_vector();
        int cyc;
        bus.out_ready = 1'b1;
        accept_and_wait(PT_A, KEY_A, 1'b0, cyc);
        n_vec++;
        if (cyc !== 32) begin
            n_fail++; $display("FAIL vector_latency got %0d want 32", cyc);
        end
        n_vec++;
        if (bus.out_block !== CT_A) begin
            n_fail++; $display("FAIL vector_result got %h want %h", bus.out_block, CT_A);
        end
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL vector_handshake got valid=%b ready=%b want 0/1", bus.out_valid,
                     bus.in_ready);
        end
    endtask

    task automatic test_stall();
        int cyc;
        bus.out_ready = 1'b0;
        accept_and_wait(PT_A, KEY_A, 1'b0, cyc);
        bus.in_valid = 1'b1;
        bus.in_block = 64'h0123456789abcdef;
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (bus.out_valid !== 1'b1 || bus.out_block !== CT_A || bus.in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold cycle %0d got v=%b blk=%h rdy=%b want 1/%h/0", i,
                         bus.out_valid, bus.out_block, bus.in_ready, CT_A);
            end
            tick();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++; $display("FAIL stall_release got valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0]  b1, b2;
        logic [255:0] k1, k2;
        int cyc, guard;
        b1 = {$urandom, $urandom};
        b2 = {$urandom, $urandom};
        k1 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        bus.out_ready = 1'b1;
        accept_and_wait(b1, k1, 1'b0, cyc);
        // accept_and_wait dropped in_valid; in_valid held back high from here on
        bus.in_valid = 1'b1;
        bus.in_block = b2;
        bus.in_key = k2;
        n_vec++;
        if (cyc !== 32 || bus.out_block !== ref_magma(b1, k1, 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_first got %h after %0d want %h after 32", bus.out_block, cyc,
                     ref_magma(b1, k1, 1'b0));
        end
        tick();
        n_vec++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap got rdy=%b v=%b want 1/0", bus.in_ready, bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++; $display("FAIL b2b_second_accept got rdy=%b want 0", bus.in_ready);
        end
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            tick();
            guard++;
        end
        n_vec++;
        if (guard !== 32 || bus.out_block !== ref_magma(b2, k2, 1'b0)) begin
            n_fail++;
            $display("FAIL b2b_second got %h after %0d want %h after 32", bus.out_block, guard,
                     ref_magma(b2, k2, 1'b0));
        end
        tick();
    endtask

    task automatic test_input_change();
        int guard;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_block = PT_A;
        bus.in_key = KEY_A;
`ifdef MAGMA_ENC_DECRYPT_EN
        bus.in_decrypt = 1'b0;
`endif
        tick();
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            bus.in_valid = 1'($urandom);
            bus.in_block = {$urandom, $urandom};
            bus.in_key = {$urandom, $urandom, $urandom, $urandom,
                          $urandom, $urandom, $urandom, $urandom};
`ifdef MAGMA_ENC_DECRYPT_EN
            bus.in_decrypt = 1'($urandom);
`endif
            tick();
            guard++;
        end
        bus.in_valid = 1'b0;
`ifdef MAGMA_ENC_DECRYPT_EN
        bus.in_decrypt = 1'b0;
`endif
        n_vec++;
        if (bus.out_block !== CT_A) begin
            n_fail++; $display("FAIL input_change got %h want %h", bus.out_block, CT_A);
        end
        tick();
    endtask

    task automatic test_mid_reset();
        int cyc;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_block = PT_A;
        bus.in_key = KEY_A;
        tick();
        bus.in_valid = 1'b0;
        repeat (15) tick();
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_block !== 64'h0) begin
            n_fail++;
            $display("FAIL mid_reset got v=%b rdy=%b blk=%h want 0/1/0", bus.out_valid,
                     bus.in_ready, bus.out_block);
        end
        tick();
        rst_n = 1'b1;
        tick();
        accept_and_wait(PT_A, KEY_A, 1'b0, cyc);
        n_vec++;
        if (cyc !== 32 || bus.out_block !== CT_A) begin
            n_fail++;
            $display("FAIL mid_reset_rerun got %h after %0d want %h after 32", bus.out_block, cyc,
                     CT_A);
        end
        tick();
    endtask

    task automatic test_random();
        logic [63:0]  b, exp;
        logic [255:0] k;
        int cyc, stall;
        for (int n = 0; n < 8; n++) begin
            b = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            exp = ref_magma(b, k, 1'b0);
            stall = int'($urandom_range(0, 4));
            bus.out_ready = (stall == 0);
            accept_and_wait(b, k, 1'b0, cyc);
            repeat (stall) tick();
            n_vec++;
            if (cyc !== 32 || bus.out_valid !== 1'b1 || bus.out_block !== exp) begin
                n_fail++;
                $display("FAIL random_%0d got %h v=%b after %0d want %h after 32", n,
                         bus.out_block, bus.out_valid, cyc, exp);
            end
            bus.out_ready = 1'b1;
            tick();
        end
    endtask

`ifdef MAGMA_ENC_DECRYPT_EN
    task automatic test_decrypt();
        logic [63:0]  b;
        logic [255:0] k;
        int cyc;
        bus.out_ready = 1'b1;
        accept_and_wait(CT_A, KEY_A, 1'b1, cyc);
        n_vec++;
        if (cyc !== 32 || bus.out_block !== PT_A) begin
            n_fail++;
            $display("FAIL decrypt_vector got %h after %0d want %h", bus.out_block, cyc, PT_A);
        end
        tick();
        for (int n = 0; n < 4; n++) begin
            b = {$urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            accept_and_wait(ref_magma(b, k, 1'b0), k, 1'b1, cyc);
            n_vec++;
            if (bus.out_block !== b) begin
                n_fail++; $display("FAIL decrypt_random_%0d got %h want %h", n, bus.out_block, b);
            end
            tick();
        end
        bus.in_decrypt = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_vector();
        test_stall();
        test_back_to_back();
        test_input_change();
        test_mid_reset();
        test_random();
`ifdef MAGMA_ENC_DECRYPT_EN
        test_decrypt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
